// File: rtl/ecap5_dproc_pkg.sv
// Shared encodings for the ECAP5-DPROC pipeline: ALU operations, branch
// conditions and the execute-stage output record.
package ecap5_dproc_pkg;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SHIFT = 3'b001,
      ALU_SLT   = 3'b010,
      ALU_SLTU  = 3'b011,
      ALU_XOR   = 3'b100,
      ALU_OR    = 3'b110,
      ALU_AND   = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      NO_BRANCH     = 3'd0,
      BRANCH_UNCOND = 3'd1,
      BRANCH_BEQ    = 3'd2,
      BRANCH_BNE    = 3'd3,
      BRANCH_BLT    = 3'd4,
      BRANCH_BGE    = 3'd5,
      BRANCH_BLTU   = 3'd6,
      BRANCH_BGEU   = 3'd7
   } branch_cond_e;

   typedef struct packed {
      logic [31:0] result;
      logic        reg_write;
      logic [4:0]  reg_addr;
      logic        ls_enable;
      logic        ls_write;
      logic        ls_unsigned_load;
      logic [31:0] ls_write_data;
      logic [3:0]  ls_sel;
   } exm_out_t;

   // Branch offset arrives in halfword units; rebuild the byte offset and sign-extend.
   function automatic logic [31:0] sext_branch_offset(input logic [19:0] off);
      return {{11{off[19]}}, off, 1'b0};
   endfunction

endpackage

// File: rtl/exm_alu.sv
// Combinational ALU for the execute stage; reserved operation codes yield zero.
module alu
   import ecap5_dproc_pkg::*;
(
   input  logic [31:0] operand1_i,
   input  logic [31:0] operand2_i,
   input  logic [2:0]  op_i,
   input  logic        sub_i,
   input  logic        shift_left_i,
   input  logic        signed_shift_i,
   output logic [31:0] result_o
);

   logic [4:0] shamt;

   assign shamt = operand2_i[4:0];

   always_comb begin
      result_o = '0;
      case (alu_op_e'(op_i))
         ALU_ADD:   result_o = sub_i ? (operand1_i - operand2_i) : (operand1_i + operand2_i);
         ALU_SHIFT: begin
            if (shift_left_i) begin
               result_o = operand1_i << shamt;
            end else if (signed_shift_i) begin
               result_o = $unsigned($signed(operand1_i) >>> shamt);
            end else begin
               result_o = operand1_i >> shamt;
            end
         end
         ALU_SLT:   result_o = {31'b0, $signed(operand1_i) < $signed(operand2_i)};
         ALU_SLTU:  result_o = {31'b0, operand1_i < operand2_i};
         ALU_XOR:   result_o = operand1_i ^ operand2_i;
         ALU_OR:    result_o = operand1_i | operand2_i;
         ALU_AND:   result_o = operand1_i & operand2_i;
         default:   result_o = '0;
      endcase
   end

endmodule

// File: rtl/exm.sv
// Execute stage: ALU, branch resolution and a single valid/ready output register
// feeding the load-store stage.
module exm
   import ecap5_dproc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,

   output logic        input_ready_o,
   input  logic        input_valid_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] alu_operand1_i,
   input  logic [31:0] alu_operand2_i,
   input  logic [2:0]  alu_op_i,
   input  logic        alu_sub_i,
   input  logic        alu_shift_left_i,
   input  logic        alu_signed_shift_i,
   input  logic [2:0]  branch_cond_i,
   input  logic [19:0] branch_offset_i,
   input  logic        reg_write_i,
   input  logic [4:0]  reg_addr_i,
   input  logic        ls_enable_i,
   input  logic        ls_write_i,
   input  logic        ls_unsigned_load_i,
   input  logic [31:0] ls_write_data_i,
   input  logic [3:0]  ls_sel_i,

   input  logic        output_ready_i,
   output logic        output_valid_o,
   output logic [31:0] result_o,
   output logic        reg_write_o,
   output logic [4:0]  reg_addr_o,
   output logic        ls_enable_o,
   output logic        ls_write_o,
   output logic        ls_unsigned_load_o,
   output logic [31:0] ls_write_data_o,
   output logic [3:0]  ls_sel_o,
   output logic        branch_o,
   output logic [31:0] branch_target_o
);

   logic [31:0] alu_result;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        accept;

   exm_out_t    out_d, out_q;
   logic        valid_d, valid_q;
   logic        branch_d, branch_q;
   logic [31:0] target_d, target_q;

   alu u_alu (
      .operand1_i     (alu_operand1_i),
      .operand2_i     (alu_operand2_i),
      .op_i           (alu_op_i),
      .sub_i          (alu_sub_i),
      .shift_left_i   (alu_shift_left_i),
      .signed_shift_i (alu_signed_shift_i),
      .result_o       (alu_result)
   );

   always_comb begin
      branch_taken = 1'b0;
      case (branch_cond_e'(branch_cond_i))
         NO_BRANCH:     branch_taken = 1'b0;
         BRANCH_UNCOND: branch_taken = 1'b1;
         BRANCH_BEQ:    branch_taken = (alu_operand1_i == alu_operand2_i);
         BRANCH_BNE:    branch_taken = (alu_operand1_i != alu_operand2_i);
         BRANCH_BLT:    branch_taken = ($signed(alu_operand1_i) <  $signed(alu_operand2_i));
         BRANCH_BGE:    branch_taken = ($signed(alu_operand1_i) >= $signed(alu_operand2_i));
         BRANCH_BLTU:   branch_taken = (alu_operand1_i <  alu_operand2_i);
         BRANCH_BGEU:   branch_taken = (alu_operand1_i >= alu_operand2_i);
         default:       branch_taken = 1'b0;
      endcase
   end

   assign branch_target = pc_i + sext_branch_offset(branch_offset_i);

   assign input_ready_o = ~rst_i & (~valid_q | output_ready_i);
   assign accept        = input_valid_i & input_ready_o;

   // branch_o is a one-cycle pulse, so it defaults low and only an accept raises it.
   always_comb begin
      out_d    = out_q;
      valid_d  = valid_q;
      branch_d = 1'b0;
      target_d = target_q;
      if (accept) begin
         out_d.result           = alu_result;
         out_d.reg_write        = reg_write_i;
         out_d.reg_addr         = reg_addr_i;
         out_d.ls_enable        = ls_enable_i;
         out_d.ls_write         = ls_write_i;
         out_d.ls_unsigned_load = ls_unsigned_load_i;
         out_d.ls_write_data    = ls_write_data_i;
         out_d.ls_sel           = ls_sel_i;
         valid_d                = 1'b1;
         branch_d               = branch_taken;
         target_d               = branch_target;
      end else if (output_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q    <= '0;
         valid_q  <= 1'b0;
         branch_q <= 1'b0;
         target_q <= '0;
      end else begin
         out_q    <= out_d;
         valid_q  <= valid_d;
         branch_q <= branch_d;
         target_q <= target_d;
      end
   end

   assign output_valid_o     = valid_q;
   assign result_o           = out_q.result;
   assign reg_write_o        = out_q.reg_write;
   assign reg_addr_o         = out_q.reg_addr;
   assign ls_enable_o        = out_q.ls_enable;
   assign ls_write_o         = out_q.ls_write;
   assign ls_unsigned_load_o = out_q.ls_unsigned_load;
   assign ls_write_data_o    = out_q.ls_write_data;
   assign ls_sel_o           = out_q.ls_sel;
   assign branch_o           = branch_q;
   assign branch_target_o    = target_q;

endmodule

// File: tb/tb_exm.sv
// Scoreboard bench for exm: a cycle model pushes expected results on accept,
// a negedge monitor compares whatever the DUT presents.
module tb_exm;

   logic        clk = 1'b0;
   logic        rst;
   logic        input_ready_o, input_valid_i;
   logic [31:0] pc_i, alu_operand1_i, alu_operand2_i;
   logic [2:0]  alu_op_i, branch_cond_i;
   logic        alu_sub_i, alu_shift_left_i, alu_signed_shift_i;
   logic [19:0] branch_offset_i;
   logic        reg_write_i, ls_enable_i, ls_write_i, ls_unsigned_load_i;
   logic [4:0]  reg_addr_i;
   logic [31:0] ls_write_data_i;
   logic [3:0]  ls_sel_i;
   logic        output_ready_i, output_valid_o;
   logic [31:0] result_o, ls_write_data_o, branch_target_o;
   logic        reg_write_o, ls_enable_o, ls_write_o, ls_unsigned_load_o, branch_o;
   logic [4:0]  reg_addr_o;
   logic [3:0]  ls_sel_o;

   exm dut (
      .clk_i(clk), .rst_i(rst),
      .input_ready_o(input_ready_o), .input_valid_i(input_valid_i),
      .pc_i(pc_i), .alu_operand1_i(alu_operand1_i), .alu_operand2_i(alu_operand2_i),
      .alu_op_i(alu_op_i), .alu_sub_i(alu_sub_i), .alu_shift_left_i(alu_shift_left_i),
      .alu_signed_shift_i(alu_signed_shift_i), .branch_cond_i(branch_cond_i),
      .branch_offset_i(branch_offset_i), .reg_write_i(reg_write_i), .reg_addr_i(reg_addr_i),
      .ls_enable_i(ls_enable_i), .ls_write_i(ls_write_i), .ls_unsigned_load_i(ls_unsigned_load_i),
      .ls_write_data_i(ls_write_data_i), .ls_sel_i(ls_sel_i),
      .output_ready_i(output_ready_i), .output_valid_o(output_valid_o), .result_o(result_o),
      .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o), .ls_enable_o(ls_enable_o),
      .ls_write_o(ls_write_o), .ls_unsigned_load_o(ls_unsigned_load_o),
      .ls_write_data_o(ls_write_data_o), .ls_sel_o(ls_sel_o),
      .branch_o(branch_o), .branch_target_o(branch_target_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, op1, op2;
      logic [2:0]  op, cond;
      logic        sub, sl, ss;
      logic [19:0] off;
      logic        rw, lse, lsw, lsu;
      logic [4:0]  ra;
      logic [31:0] wd;
      logic [3:0]  sel;
   } txn_t;

   typedef struct {
      logic [31:0] result;
      logic [44:0] pt;
   } exp_t;

   exp_t        exp_q[$];
   logic        m_valid = 1'b0;
   logic        exp_branch = 1'b0;
   logic [31:0] exp_target = '0;
   logic        exp_zero = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          pop_cnt = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference arithmetic written directly from the ISA meaning of each operation.
   function automatic logic [31:0] ref_result(input txn_t t);
      int unsigned sh = t.op2 & 32'd31;
      case (t.op)
         3'd0: return t.sub ? t.op1 - t.op2 : t.op1 + t.op2;
         3'd1: begin
            if (t.sl) return t.op1 << sh;
            if (t.ss && t.op1[31]) return ~((~t.op1) >> sh);
            return t.op1 >> sh;
         end
         3'd2: return ($signed(t.op1) < $signed(t.op2)) ? 32'd1 : 32'd0;
         3'd3: return (t.op1 < t.op2) ? 32'd1 : 32'd0;
         3'd4: return t.op1 ^ t.op2;
         3'd6: return t.op1 | t.op2;
         3'd7: return t.op1 & t.op2;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic ref_taken(input txn_t t);
      int a = t.op1;
      int b = t.op2;
      case (t.cond)
         3'd0: return 1'b0;
         3'd1: return 1'b1;
         3'd2: return a == b;
         3'd3: return a != b;
         3'd4: return a < b;
         3'd5: return a >= b;
         3'd6: return t.op1 < t.op2;
         default: return t.op1 >= t.op2;
      endcase
   endfunction

   function automatic logic [31:0] ref_target(input txn_t t);
      int byte_off = $signed({t.off, 1'b0});
      return t.pc + 32'(byte_off);
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      t.pc   = $urandom & 32'hFFFF_FFFC;
      t.op1  = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      t.op2  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) t.op2 = t.op1;
      t.op   = 3'($urandom_range(0, 7));
      t.cond = 3'($urandom_range(0, 7));
      t.sub  = 1'($urandom);
      t.sl   = 1'($urandom);
      t.ss   = 1'($urandom);
      t.off  = 20'($urandom);
      t.rw   = 1'($urandom);
      t.lse  = 1'($urandom);
      t.lsw  = 1'($urandom);
      t.lsu  = 1'($urandom);
      t.ra   = 5'($urandom);
      t.wd   = $urandom;
      t.sel  = 4'($urandom);
      return t;
   endfunction

   function automatic txn_t zero_txn();
      txn_t t;
      t.pc = '0; t.op1 = '0; t.op2 = '0; t.op = '0; t.cond = '0;
      t.sub = 0; t.sl = 0; t.ss = 0; t.off = '0; t.rw = 0; t.lse = 0;
      t.lsw = 0; t.lsu = 0; t.ra = '0; t.wd = '0; t.sel = '0;
      return t;
   endfunction

   task automatic apply(input txn_t t, input logic v);
      input_valid_i = v;
      pc_i = t.pc; alu_operand1_i = t.op1; alu_operand2_i = t.op2;
      alu_op_i = t.op; alu_sub_i = t.sub; alu_shift_left_i = t.sl;
      alu_signed_shift_i = t.ss; branch_cond_i = t.cond; branch_offset_i = t.off;
      reg_write_i = t.rw; reg_addr_i = t.ra; ls_enable_i = t.lse; ls_write_i = t.lsw;
      ls_unsigned_load_i = t.lsu; ls_write_data_i = t.wd; ls_sel_i = t.sel;
   endtask

   function automatic txn_t cur_txn();
      txn_t t;
      t.pc = pc_i; t.op1 = alu_operand1_i; t.op2 = alu_operand2_i; t.op = alu_op_i;
      t.cond = branch_cond_i; t.sub = alu_sub_i; t.sl = alu_shift_left_i;
      t.ss = alu_signed_shift_i; t.off = branch_offset_i; t.rw = reg_write_i;
      t.lse = ls_enable_i; t.lsw = ls_write_i; t.lsu = ls_unsigned_load_i;
      t.ra = reg_addr_i; t.wd = ls_write_data_i; t.sel = ls_sel_i;
      return t;
   endfunction

   // Cycle model: one output slot, occupancy tracked independently of the DUT.
   always @(posedge clk) begin
      txn_t t;
      exp_t e;
      if (rst) begin
         m_valid = 1'b0;
         exp_q.delete();
         exp_branch = 1'b0;
         exp_zero = 1'b1;
      end else begin
         exp_zero = 1'b0;
         if (input_valid_i && (!m_valid || output_ready_i)) begin
            t = cur_txn();
            e.result = ref_result(t);
            e.pt = {t.rw, t.ra, t.lse, t.lsw, t.lsu, t.wd, t.sel};
            exp_q.push_back(e);
            m_valid = 1'b1;
            exp_branch = ref_taken(t);
            exp_target = ref_target(t);
         end else begin
            if (output_ready_i) m_valid = 1'b0;
            exp_branch = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      check("input_ready", 128'(input_ready_o), 128'(!rst && (!m_valid || output_ready_i)));
      check("output_valid", 128'(output_valid_o), 128'(m_valid));
      check("branch", 128'(branch_o), 128'(exp_branch));
      if (exp_branch) check("branch_target", 128'(branch_target_o), 128'(exp_target));
      if (exp_zero)
         check("reset_outputs",
               {output_valid_o, branch_o, result_o, branch_target_o, reg_write_o, reg_addr_o,
                ls_enable_o, ls_write_o, ls_unsigned_load_o, ls_write_data_o, ls_sel_o}, '0);
      if (output_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: output valid but nothing expected at %0t", $time);
         end else begin
            check("result", 128'(result_o), 128'(exp_q[0].result));
            check("passthrough",
                  128'({reg_write_o, reg_addr_o, ls_enable_o, ls_write_o, ls_unsigned_load_o,
                        ls_write_data_o, ls_sel_o}), 128'(exp_q[0].pt));
            if (output_ready_i) begin
               void'(exp_q.pop_front());
               pop_cnt++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      txn_t t, t2;
      rst = 1'b1;
      output_ready_i = 1'b1;
      apply(zero_txn(), 1'b0);
      repeat (3) step();
      rst = 1'b0;

      t = zero_txn(); t.op1 = 32'd7; t.op2 = 32'hFFFF_FFFF; t.sub = 1'b1;
      apply(t, 1'b1); step();
      check("add_sub_result", 128'(result_o), 128'd8);
      check("add_sub_valid", 128'(output_valid_o), 128'd1);

      t = zero_txn(); t.op = 3'd1; t.op1 = 32'h8000_0000; t.op2 = 32'd4; t.ss = 1'b1;
      apply(t, 1'b1); step();
      check("sra", 128'(result_o), 128'h F800_0000);
      t.ss = 1'b0;
      apply(t, 1'b1); step();
      check("srl", 128'(result_o), 128'h 0800_0000);

      t = zero_txn(); t.cond = 3'd4; t.op1 = 32'hFFFF_FFFF; t.op2 = 32'd1;
      t.pc = 32'h100; t.off = 20'hFFFFE;
      apply(t, 1'b1); step();
      check("blt_taken", 128'(branch_o), 128'd1);
      check("blt_target", 128'(branch_target_o), 128'h FC);
      t.cond = 3'd6;
      apply(t, 1'b1); step();
      check("bltu_not_taken", 128'(branch_o), 128'd0);

      apply(zero_txn(), 1'b0); step();
      output_ready_i = 1'b0;
      t = rand_txn(); t.cond = 3'd1;
      apply(t, 1'b1); step();
      t2 = rand_txn();
      apply(t2, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_ready", 128'(input_ready_o), 128'd0);
         check("stall_result", 128'(result_o), 128'(ref_result(t)));
      end
      output_ready_i = 1'b1; step();
      check("after_stall_result", 128'(result_o), 128'(ref_result(t2)));

      output_ready_i = 1'b0;
      t = rand_txn(); t.cond = 3'd1;
      apply(zero_txn(), 1'b0); step();
      apply(t, 1'b1); step();
      apply(t, 1'b1); step();
      rst = 1'b1; step();
      rst = 1'b0;
      check("rst_stall_valid", 128'(output_valid_o), 128'd0);
      check("rst_stall_branch", 128'(branch_o), 128'd0);
      output_ready_i = 1'b1;
      apply(zero_txn(), 1'b0); step();

      pop_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         apply(rand_txn(), 1'b1); step();
      end
      apply(zero_txn(), 1'b0);
      repeat (2) step();
      check("stream_count", 128'(pop_cnt), 128'd16);

      for (int i = 0; i < 300; i++) begin
         output_ready_i = ($urandom_range(0, 2) != 0);
         apply(rand_txn(), $urandom_range(0, 3) != 0);
         step();
      end

      output_ready_i = 1'b1;
      apply(zero_txn(), 1'b0);
      repeat (3) step();
      check("drained", 128'(exp_q.size()), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
